// File: rtl/ps2_host_tx_if.sv
// Signal bundle between the PS/2 host transmitter and its surroundings:
// the command handshake plus the raw pin levels and pull-down enables.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic       ps2_clock_in;
  logic       ps2_data_in;
  logic       ps2_clock_oe;
  logic       ps2_data_oe;

  // master: command issuer and pad logic; slave: the transmitter itself
  modport master (
    output tx_data, tx_start, ps2_clock_in, ps2_data_in,
    input  tx_busy, tx_done, tx_error, ps2_clock_oe, ps2_data_oe
  );

  modport slave (
    input  tx_data, tx_start, ps2_clock_in, ps2_data_in,
    output tx_busy, tx_done, tx_error, ps2_clock_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, LSB-first frame with odd
// parity shifted on device clock falls, ACK check and inter-edge watchdog.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int SETUP_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic          clock,
  input  logic          reset,
  ps2_host_tx_if.slave  bus
);

  localparam int MAX_A   = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int MAX_CNT = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, SETUP, WAIT_EDGES, WAIT_IDLE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_cnt;
  logic [9:0]       frame;
  logic             busy, done, error, clock_oe, data_oe;

  logic clk_meta, clk_sync, clk_prev;
  logic data_meta, data_sync;
  logic clk_fall;

  // NOTE: synchronizers reset to the idle-high line level so leaving reset never fakes an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= bus.ps2_clock_in;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= bus.ps2_data_in;
      data_sync <= data_meta;
    end
  end

  assign clk_fall = clk_prev & ~clk_sync;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      frame    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      clock_oe <= 1'b0;
      data_oe  <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          clock_oe <= 1'b0;
          data_oe  <= 1'b0;
          // a start coinciding with the completion pulse is dropped
          if (bus.tx_start && !done && !error) begin
            frame    <= {1'b1, ~^bus.tx_data, bus.tx_data};
            state    <= INHIBIT;
            busy     <= 1'b1;
            clock_oe <= 1'b1;
            cnt      <= '0;
            bit_cnt  <= '0;
          end
        end
        INHIBIT: begin
          if (cnt == INH_LAST) begin
            cnt     <= '0;
            data_oe <= 1'b1;
            state   <= SETUP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt      <= '0;
            clock_oe <= 1'b0;
            state    <= WAIT_EDGES;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_EDGES: begin
          // an edge wins over a simultaneous watchdog expiry
          if (clk_fall) begin
            cnt <= '0;
            if (bit_cnt != 4'd10) begin
              bit_cnt <= bit_cnt + 4'd1;
              data_oe <= ~frame[0];
              frame   <= {1'b0, frame[9:1]};
            end else if (!data_sync) begin
              state <= WAIT_IDLE;
            end else begin
              error   <= 1'b1;
              busy    <= 1'b0;
              data_oe <= 1'b0;
              state   <= IDLE;
            end
          end else if (cnt == TO_LAST) begin
            error    <= 1'b1;
            busy     <= 1'b0;
            clock_oe <= 1'b0;
            data_oe  <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (clk_sync && data_sync) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == TO_LAST) begin
            error    <= 1'b1;
            busy     <= 1'b0;
            clock_oe <= 1'b0;
            data_oe  <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_busy      = busy;
  assign bus.tx_done      = done;
  assign bus.tx_error     = error;
  assign bus.ps2_clock_oe = clock_oe;
  assign bus.ps2_data_oe  = data_oe;

endmodule
